uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

- Buffered transmit front-end between the UART control logic and `Uart_Tx`.
- Accepts bytes on a single-cycle write strobe and stores them in a circular FIFO.
- Drains them one at a time into `Uart_Tx` through its `Data_Tx`/`Wrsig`/`Idle` handshake, with a guaranteed inter-frame gap.
- Replaces free-running delay counters in the controller: a whole message can be pushed back-to-back and serialised without loss.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO depth = 2^DEPTH_LOG2 entries (16).
- GAP_CYCLES, 16: minimum Uart_CLK cycles between the end of one frame and the next `Wrsig`.
- BUSY_TIMEOUT, 32: cycles to wait for `Idle` to rise after `Wrsig` before the byte is treated as sent.

Ports:
- Uart_CLK  in  1  sole clock (baud-derived clock from `Uart_ClkDiv`).
- Sys_RST  in  1  asynchronous, active-low reset.
- Data_In  in  8  byte to enqueue.
- Wr_En  in  1  enqueue strobe; one byte per cycle high.
- Full  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- Empty  out  1  FIFO holds 0 bytes.
- Count  out  DEPTH_LOG2+1  current occupancy.
- Data_Tx  out  8  byte presented to `Uart_Tx`.
- Wrsig  out  1  one-cycle start pulse to `Uart_Tx`.
- Idle  in  1  from `Uart_Tx`; high while a frame is being shifted out (busy).
- Overflow  out  1  sticky write-while-full flag; see Configuration.
- Ovf_Clr  in  1  clears `Overflow`.

## Operation
- Storage: circular buffer with `DEPTH_LOG2`-bit read/write pointers that wrap modulo depth. `Count` is a separate up/down counter.
- Push: `Wr_En` && (!Full || pop this cycle) writes `Data_In` at the write pointer, then the write pointer increments.
  - `Wr_En` && Full with no pop: byte is dropped. Pointers and `Count` are unchanged.
- Pop: occurs only on the ST_IDLE→ST_LOAD transition.
  - Simultaneous push and pop: `Count` is unchanged and both pointers advance.
- Drain FSM:
  - ST_IDLE: `Wrsig`=0. When !Empty && !Idle, go to ST_LOAD, register the head byte into `Data_Tx`, and advance the read pointer.
  - ST_LOAD: `Data_Tx` is stable. Go to ST_STROBE and set `Wrsig`=1.
  - ST_STROBE: `Wrsig`=0. Go to ST_WAIT_BUSY and clear the timer.
  - ST_WAIT_BUSY: if `Idle`, go to ST_WAIT_DONE. If the timer reaches BUSY_TIMEOUT−1, go to ST_GAP (the byte is considered lost and is not retried).
  - ST_WAIT_DONE: when !`Idle`, go to ST_GAP and clear the timer.
  - ST_GAP: count GAP_CYCLES, then go to ST_IDLE.
  - Unreachable encodings: go to ST_IDLE with `Wrsig`=0.
- `Data_Tx` holds the last loaded byte until the next ST_LOAD.
- Reset (async, any state, including mid-frame):
  - FSM state: ST_IDLE.
  - Pointers, `Count`, timer: 0.
  - `Data_Tx`: 8'h00.
  - `Wrsig`: 0.
  - `Overflow`: 0.
  - `Empty`: 1; `Full`: 0.
  - FIFO contents are discarded. A frame already in `Uart_Tx` is not aborted.

## Timing
- All outputs are registered, except `Full`/`Empty`, which are decoded from the registered `Count`.
- `Wr_En` sampled at edge k into an empty FIFO with an idle FSM and `Idle`=0:
  - `Empty` falls after edge k.
  - Pop and `Data_Tx` valid after edge k+1.
  - `Wrsig`=1 for exactly the cycle between edges k+2 and k+3.
- `Data_Tx` is valid one full cycle before `Wrsig` rises and stays stable until at least the next ST_LOAD.
- Throughput: at most one byte per (frame length + GAP_CYCLES + 3) cycles.
- No `Wrsig` pulse is ever issued while `Idle`=1.

## Configuration
- Macro: `UART_TX_FIFO_OVF_EN`.
- Defined:
  - `Overflow` is set on the cycle a push is dropped and stays set until `Ovf_Clr`.
  - If set and clear occur in the same cycle, set wins.
- Undefined:
  - `Overflow` is tied to 0 and `Ovf_Clr` is ignored.
  - Drop behaviour on write-while-full is identical.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (3-bit, ST_IDLE…ST_GAP).
  - Byte width 8.
  - ASCII constants CR=8'd13, SPACE=8'd32.
- Sub-module `uart_fifo_mem`:
  - 2^DEPTH_LOG2×8 storage.
  - Synchronous write; registered read addressed by the read pointer.
  - Pointers, count and FSM stay in the top.

## Test plan
- Push 8'h52 into an empty FIFO with `Idle`=0 → `Data_Tx`=8'h52 after edge k+1, one-cycle `Wrsig` at edge k+2, `Count` returns to 0.
- Push 16 bytes 8'h00..8'h0F back-to-back with `Idle` held 1 → `Full`=1, `Count`=16. Push 8'hAA → dropped; `Overflow`=1 with the macro defined, 0 without.
- Release `Idle`, then model a 160-cycle busy per frame → 16 `Wrsig` pulses, bytes in order 00..0F, each pulse ≥ GAP_CYCLES after the prior `Idle` fall.
- With `Full` and the FSM popping, push 8'h55 in the pop cycle → accepted, `Count` stays 16, 8'h55 is emitted last.
- `Idle` never rises after `Wrsig` → FSM passes through ST_GAP after 32 cycles and issues the next byte; no deadlock.
- Assert `Sys_RST` low mid-ST_WAIT_DONE with 5 bytes queued → immediately `Wrsig`=0, `Count`=0, `Empty`=1, `Data_Tx`=0; no pulses after release until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path:
//   - tx_state_e : 3-bit encoding of the transmit-FIFO drain FSM
//   - BYTE_W     : width of a UART data byte
//   - CR, SPACE  : ASCII constants used by the message-building controller
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CR    = 8'd13;
    localparam logic [BYTE_W-1:0] SPACE = 8'd32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_STROBE    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_fifo_mem
// 2^DEPTH_LOG2 x 8 storage for the UART transmit FIFO.
// Synchronous write; registered read that only updates when rd_en is high, so
// the read register doubles as the held byte presented to the transmitter.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (clears the read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   load the read register from rd_addr
//   rd_addr  in   read address
//   rd_data  out  registered read data, holds between reads
// -----------------------------------------------------------------------------
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [BYTE_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [BYTE_W-1:0]     rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [BYTE_W-1:0] mem_r [DEPTH];
    logic [BYTE_W-1:0] rd_data_r;

    // Storage array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read; a same-address write in the same cycle returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= 8'h00;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered transmit front-end for Uart_Tx. Bytes written on Wr_En are queued in
// a circular FIFO and drained one at a time through the Data_Tx/Wrsig/Idle
// handshake, with at least GAP_CYCLES idle cycles between frames.
// Optional feature macro: UART_TX_FIFO_OVF_EN enables the sticky Overflow flag;
// without it Overflow is tied low and Ovf_Clr is ignored.
// Ports:
//   Uart_CLK  in   clock
//   Sys_RST   in   asynchronous active-low reset
//   Data_In   in   byte to enqueue
//   Wr_En     in   enqueue strobe
//   Full      out  FIFO holds 2^DEPTH_LOG2 bytes
//   Empty     out  FIFO holds no bytes
//   Count     out  occupancy
//   Data_Tx   out  byte presented to Uart_Tx
//   Wrsig     out  one-cycle start pulse to Uart_Tx
//   Idle      in   Uart_Tx busy indication (high while shifting)
//   Overflow  out  sticky write-while-full flag
//   Ovf_Clr   in   clears Overflow
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter int GAP_CYCLES   = 16,
    parameter int BUSY_TIMEOUT = 32
) (
    input  logic                  Uart_CLK,
    input  logic                  Sys_RST,
    input  logic [BYTE_W-1:0]     Data_In,
    input  logic                  Wr_En,
    output logic                  Full,
    output logic                  Empty,
    output logic [DEPTH_LOG2:0]   Count,
    output logic [BYTE_W-1:0]     Data_Tx,
    output logic                  Wrsig,
    input  logic                  Idle,
    output logic                  Overflow,
    input  logic                  Ovf_Clr
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int CNT_W   = DEPTH_LOG2 + 1;
    localparam int TMR_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    tx_state_e             state_r;
    tx_state_e             state_s;
    logic [TMR_W-1:0]      timer_r;
    logic [TMR_W-1:0]      timer_s;
    logic                  wrsig_r;
    logic                  wrsig_s;
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  pop_s;
    logic                  push_s;

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // A push into a full FIFO is still accepted when the drain FSM frees a slot
    // in the same cycle.
    assign push_s = Wr_En && (!full_s || pop_s);

    // Drain FSM next-state, timer and start-pulse decode.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        wrsig_s = 1'b0;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s && !Idle) begin
                    state_s = ST_LOAD;
                    pop_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_STROBE;
                wrsig_s = 1'b1;
            end
            ST_STROBE: begin
                state_s = ST_WAIT_BUSY;
                timer_s = {TMR_W{1'b0}};
            end
            ST_WAIT_BUSY: begin
                if (Idle) begin
                    state_s = ST_WAIT_DONE;
                end else if (timer_r == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged: drop the byte, keep draining.
                    state_s = ST_GAP;
                    timer_s = {TMR_W{1'b0}};
                end else begin
                    timer_s = timer_r + TMR_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!Idle) begin
                    state_s = ST_GAP;
                    timer_s = {TMR_W{1'b0}};
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (timer_r == TMR_W'(GAP_CYCLES - 1)) begin
                    state_s = ST_IDLE;
                    timer_s = {TMR_W{1'b0}};
                end else begin
                    timer_s = timer_r + TMR_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = {TMR_W{1'b0}};
            end
        endcase
    end

    // Drain FSM state, timer and registered start pulse.
    always_ff @(posedge Uart_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            state_r <= ST_IDLE;
            timer_r <= {TMR_W{1'b0}};
            wrsig_r <= 1'b0;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            wrsig_r <= wrsig_s;
        end
    end

    // FIFO pointers and occupancy counter.
    always_ff @(posedge Uart_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // The memory's read register is loaded on the pop and is Data_Tx itself.
    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (Uart_CLK),
        .rst_n   (Sys_RST),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (Data_In),
        .rd_en   (pop_s),
        .rd_addr (rd_ptr_r),
        .rd_data (Data_Tx)
    );

`ifdef UART_TX_FIFO_OVF_EN
    logic drop_s;
    logic overflow_r;

    assign drop_s = Wr_En && full_s && !pop_s;

    // Sticky overflow flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge Uart_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (Ovf_Clr) begin
            overflow_r <= 1'b0;
        end
    end

    assign Overflow = overflow_r;
`else
    logic ovf_clr_unused_s;

    assign ovf_clr_unused_s = Ovf_Clr;
    assign Overflow         = 1'b0;
`endif

    assign Wrsig = wrsig_r;
    assign Count = count_r;
    assign Full  = full_s;
    assign Empty = empty_s;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        wr_en;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic [7:0]  data_tx;
    logic        wrsig;
    logic        idle;
    logic        overflow;
    logic        ovf_clr;

    logic        idle_force;
    logic        idle_model;
    int          busy_len;
    int          busy_cnt;
    int          cyc;
    int          viol;
    int          n_cmp;
    int          n_bad;
    logic [7:0]  tx_bytes [$];
    int          pulse_cyc [$];
    int          fall_cyc [$];
    logic        exp_ovf;

    assign idle = idle_force | idle_model;

    uart_tx_fifo #(
        .DEPTH_LOG2   (4),
        .GAP_CYCLES   (16),
        .BUSY_TIMEOUT (32)
    ) dut (
        .Uart_CLK (clk),
        .Sys_RST  (rst_n),
        .Data_In  (data_in),
        .Wr_En    (wr_en),
        .Full     (full),
        .Empty    (empty),
        .Count    (count),
        .Data_Tx  (data_tx),
        .Wrsig    (wrsig),
        .Idle     (idle),
        .Overflow (overflow),
        .Ovf_Clr  (ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Uart_Tx stand-in: logs each start pulse and raises busy for busy_len cycles.
    initial begin
        idle_model = 1'b0;
        busy_cnt   = 0;
        viol       = 0;
        forever begin
            @(negedge clk);
            if (wrsig) begin
                if (idle) viol++;
                tx_bytes.push_back(data_tx);
                pulse_cyc.push_back(cyc);
                if (busy_len > 0) begin
                    idle_model = 1'b1;
                    busy_cnt   = busy_len;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    idle_model = 1'b0;
                    fall_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d n_bad=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pulses(input int n, input int budget, input string tag);
        int b;
        b = 0;
        while (tx_bytes.size() < n && b < budget) begin
            @(posedge clk);
            b++;
        end
        #1;
        chk(tag, tx_bytes.size(), n);
    endtask

    initial begin
`ifdef UART_TX_FIFO_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        data_in    = 8'h00;
        wr_en      = 1'b0;
        ovf_clr    = 1'b0;
        idle_force = 1'b0;
        busy_len   = 20;

        // Reset state
        tick(3);
        chk("rst_count", count, 5'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_wrsig", wrsig, 1'b0);
        chk("rst_data_tx", data_tx, 8'h00);
        chk("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // Single byte: exact handshake timing
        data_in = 8'h52;
        wr_en   = 1'b1;
        tick(1);
        wr_en = 1'b0;
        chk("t1_empty_k", empty, 1'b0);
        chk("t1_count_k", count, 5'd1);
        chk("t1_wrsig_k", wrsig, 1'b0);
        tick(1);
        chk("t1_data_k1", data_tx, 8'h52);
        chk("t1_count_k1", count, 5'd0);
        chk("t1_wrsig_k1", wrsig, 1'b0);
        tick(1);
        chk("t1_wrsig_k2", wrsig, 1'b1);
        tick(1);
        chk("t1_wrsig_k3", wrsig, 1'b0);
        tick(60);
        chk("t1_pulses", tx_bytes.size(), 1);
        chk("t1_byte", tx_bytes[0], 8'h52);
        chk("t1_empty_end", empty, 1'b1);

        // Fill to full while the transmitter reports busy, then overflow
        idle_force = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_in = 8'(i);
            wr_en   = 1'b1;
            tick(1);
        end
        wr_en = 1'b0;
        chk("t2_count16", count, 5'd16);
        chk("t2_full", full, 1'b1);
        chk("t2_ovf_pre", overflow, 1'b0);
        data_in = 8'hAA;
        wr_en   = 1'b1;
        tick(1);
        wr_en = 1'b0;
        chk("t2_count_drop", count, 5'd16);
        chk("t2_ovf_set", overflow, exp_ovf);
        tick(2);
        chk("t2_ovf_sticky", overflow, exp_ovf);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("t2_ovf_clr", overflow, 1'b0);

        // Drain with 160-cycle frames; push 0x55 in the first pop cycle
        tx_bytes.delete();
        pulse_cyc.delete();
        fall_cyc.delete();
        busy_len   = 160;
        idle_force = 1'b0;
        data_in    = 8'h55;
        wr_en      = 1'b1;
        tick(1);
        wr_en = 1'b0;
        chk("t3_count_pushpop", count, 5'd16);
        chk("t3_full_pushpop", full, 1'b1);
        chk("t3_data_first", data_tx, 8'h00);
        wait_pulses(17, 5000, "t3_pulses_timeout");
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("t3_byte%0d", i), tx_bytes[i], (i < 16) ? 32'(i) : 32'h55);
        end
        for (int i = 1; i < 17; i++) begin
            chk($sformatf("t3_gap%0d", i), 32'((pulse_cyc[i] - fall_cyc[i-1]) >= 16), 32'd1);
        end
        tick(200);
        chk("t3_empty_end", empty, 1'b1);

        // Transmitter never acknowledges: timeout plus gap, then next byte
        tx_bytes.delete();
        pulse_cyc.delete();
        busy_len = 0;
        data_in  = 8'hC1;
        wr_en    = 1'b1;
        tick(1);
        data_in = 8'hC2;
        tick(1);
        wr_en = 1'b0;
        wait_pulses(2, 300, "t5_pulses_timeout");
        chk("t5_byte0", tx_bytes[0], 8'hC1);
        chk("t5_byte1", tx_bytes[1], 8'hC2);
        chk("t5_spacing", pulse_cyc[1] - pulse_cyc[0], 32'd51);
        tick(80);

        // Reset mid-frame with five bytes still queued
        tx_bytes.delete();
        pulse_cyc.delete();
        busy_len = 160;
        for (int i = 0; i < 6; i++) begin
            data_in = 8'hD0 + 8'(i);
            wr_en   = 1'b1;
            tick(1);
        end
        wr_en = 1'b0;
        wait_pulses(1, 50, "t6_pulse_timeout");
        tick(20);
        chk("t6_count_q", count, 5'd5);
        chk("t6_byte0", tx_bytes[0], 8'hD0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wrsig", wrsig, 1'b0);
        chk("t6_rst_count", count, 5'd0);
        chk("t6_rst_empty", empty, 1'b1);
        chk("t6_rst_full", full, 1'b0);
        chk("t6_rst_data", data_tx, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(300);
        chk("t6_no_pulse", tx_bytes.size(), 1);
        data_in = 8'hE7;
        wr_en   = 1'b1;
        tick(1);
        wr_en = 1'b0;
        wait_pulses(2, 100, "t6_new_timeout");
        chk("t6_new_byte", tx_bytes[1], 8'hE7);

        chk("no_wrsig_busy", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
